// File: rtl/multichannel_integrator.sv
// Time-multiplexed N-channel trapezoidal integrator with one shared multiplier/adder.
// Two-stage pipeline: stage 1 registers the sample, stage 2 updates the channel state.
module multichannel_integrator #(
  parameter int                     NCH      = 4,
  parameter int                     CHW      = 2,
  parameter int                     DW       = 24,
  parameter int                     CW       = 16,
  parameter int                     CF       = 16,
  parameter int                     IW       = DW + CW,
  parameter logic signed [CW-1:0]   KI_RST   = 16'sd98,
  parameter logic signed [IW-1:0]   MAX      = 40'sd412316860416,
  parameter logic signed [IW-1:0]   MIN      = -40'sd412316860416,
  parameter int                     SAT_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_in,
  input  logic [CHW-1:0]        ch_in,
  input  logic signed [DW-1:0]  sig_in,
  input  logic                  clr_in,
  input  logic                  ki_we,
  input  logic signed [CW-1:0]  ki_in,
  output logic                  ce_out,
  output logic [CHW-1:0]        ch_out,
  output logic signed [DW-1:0]  sig_out,
  output logic                  sat_out
);

  localparam int          SW    = IW + 2;
  localparam int unsigned NCH_U = NCH;

  logic                  ce_buf;
  logic [CHW-1:0]        ch_buf;
  logic signed [DW-1:0]  u_buf;
  logic                  clr_buf;
  logic signed [CW-1:0]  ki;
  logic signed [CW-1:0]  ki_eff;

  logic signed [IW-1:0]  y_mem [NCH];
  logic signed [IW-1:0]  x_mem [NCH];

  logic signed [IW-1:0]  y_cur;
  logic signed [IW-1:0]  x_cur;
  logic signed [IW-1:0]  k;
  logic signed [SW-1:0]  s;
  logic                  ovf_hi;
  logic                  ovf_lo;
  logic signed [IW-1:0]  y_new;
  logic signed [IW-1:0]  x_new;
  logic                  ch_ok;

  assign ch_ok = (32'(ch_in) < NCH_U);

  // Stage 1: sample register; out-of-range channels are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_buf  <= 1'b0;
      ch_buf  <= '0;
      u_buf   <= '0;
      clr_buf <= 1'b0;
    end else begin
      ce_buf  <= ce_in && ch_ok;
      ch_buf  <= ch_in;
      u_buf   <= sig_in;
      clr_buf <= clr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ki <= KI_RST;
    end else if (ki_we) begin
      ki <= ki_in;
    end
  end

  // A gain written on this edge already applies to the sample sitting in stage 1.
  assign ki_eff = ki_we ? ki_in : ki;

  always_comb begin
    y_cur  = y_mem[ch_buf];
    x_cur  = x_mem[ch_buf];
    k      = ki_eff * u_buf;
    // Sum is formed two bits wider so a true overflow can never wrap back into range.
    s      = $signed({{2{y_cur[IW-1]}}, y_cur}) + $signed({{2{x_cur[IW-1]}}, x_cur})
           + $signed({{2{k[IW-1]}}, k});
    ovf_hi = s > $signed({{2{MAX[IW-1]}}, MAX});
    ovf_lo = s < $signed({{2{MIN[IW-1]}}, MIN});
    y_new  = s[IW-1:0];
    x_new  = k;
    if (clr_buf) begin
      y_new = '0;
      x_new = '0;
    end else if (ovf_hi || ovf_lo) begin
      if (SAT_MODE != 0) begin
        y_new = ovf_hi ? MAX : MIN;
      end else begin
        y_new = y_cur;
      end
    end
  end

  // Stage 2: channel state update; only the addressed channel is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH_U; i++) begin
        y_mem[i] <= '0;
        x_mem[i] <= '0;
      end
    end else if (ce_buf) begin
      y_mem[ch_buf] <= y_new;
      x_mem[ch_buf] <= x_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_out  <= 1'b0;
      ch_out  <= '0;
      sig_out <= '0;
      sat_out <= 1'b0;
    end else begin
      ce_out <= ce_buf;
      if (ce_buf) begin
        ch_out  <= ch_buf;
        sig_out <= y_new[DW+CF-1:CF];
        sat_out <= (ovf_hi || ovf_lo) && !clr_buf;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_integrator.sv
// Self-checking bench: clamp build, hold build and a 3-channel build driven in parallel,
// results checked through a scoreboard queue of hand-computed expectations.
module tb_multichannel_integrator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce_in = 1'b0;
  logic [1:0]         ch_in = '0;
  logic signed [23:0] sig_in = '0;
  logic               clr_in = 1'b0;
  logic               ki_we = 1'b0;
  logic signed [15:0] ki_in = '0;

  logic               ce_a, ce_b, ce_c;
  logic [1:0]         ch_a, ch_b, ch_c;
  logic signed [23:0] sig_a, sig_b, sig_c;
  logic               sat_a, sat_b, sat_c;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multichannel_integrator dut_a (
    .clk(clk), .rst(rst), .ce_in(ce_in), .ch_in(ch_in), .sig_in(sig_in), .clr_in(clr_in),
    .ki_we(ki_we), .ki_in(ki_in), .ce_out(ce_a), .ch_out(ch_a), .sig_out(sig_a), .sat_out(sat_a)
  );

  multichannel_integrator #(.SAT_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .ce_in(ce_in), .ch_in(ch_in), .sig_in(sig_in), .clr_in(clr_in),
    .ki_we(ki_we), .ki_in(ki_in), .ce_out(ce_b), .ch_out(ch_b), .sig_out(sig_b), .sat_out(sat_b)
  );

  multichannel_integrator #(.NCH(3), .CHW(2)) dut_c (
    .clk(clk), .rst(rst), .ce_in(ce_in), .ch_in(ch_in), .sig_in(sig_in), .clr_in(clr_in),
    .ki_we(ki_we), .ki_in(ki_in), .ce_out(ce_c), .ch_out(ch_c), .sig_out(sig_c), .sat_out(sat_c)
  );

  typedef struct {
    int ch;
    int u;
    bit clr;
    bit ki_wr;
    int ki;
    int sig;
    bit sat;
    int sig_h;
  } vec_t;

  typedef struct {
    int id;
    int ch;
    int sig_a;
    int sig_b;
    bit sat;
    int cyc;
  } exp_t;

  exp_t q_ab[$];
  exp_t q_c[$];
  vec_t tbl[18];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int ch, input int sa, input int sb, input bit sat);
    exp_t e;
    e.id = id; e.ch = ch; e.sig_a = sa; e.sig_b = sb; e.sat = sat; e.cyc = cyc;
    q_ab.push_back(e);
    if (ch < 3) q_c.push_back(e);
  endtask

  task automatic send(input int ch, input int u, input bit clr);
    @(negedge clk);
    ce_in = 1'b1; ch_in = 2'(ch); sig_in = 24'(u); clr_in = clr;
  endtask

  task automatic idle();
    @(negedge clk);
    ce_in = 1'b0; clr_in = 1'b0; ki_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_ab.size() != 0 || q_c.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", longint'(q_ab.size() + q_c.size()), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ce"}, longint'({ce_a, ce_b, ce_c}), 0);
    chk({tag, "_ch"}, longint'({ch_a, ch_b, ch_c}), 0);
    chk({tag, "_sig_a"}, sig_a, 0);
    chk({tag, "_sig_b"}, sig_b, 0);
    chk({tag, "_sig_c"}, sig_c, 0);
    chk({tag, "_sat"}, longint'({sat_a, sat_b, sat_c}), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && (ce_a || ce_b)) begin
      if (q_ab.size() == 0) begin
        chk("spurious_ce_ab", 1, 0);
      end else begin
        exp_t e;
        e = q_ab.pop_front();
        chk($sformatf("r%0d_ce_a", e.id), ce_a, 1);
        chk($sformatf("r%0d_ce_b", e.id), ce_b, 1);
        chk($sformatf("r%0d_latency", e.id), cyc - e.cyc, 2);
        chk($sformatf("r%0d_ch_a", e.id), ch_a, e.ch);
        chk($sformatf("r%0d_ch_b", e.id), ch_b, e.ch);
        chk($sformatf("r%0d_sig_a", e.id), sig_a, e.sig_a);
        chk($sformatf("r%0d_sig_b", e.id), sig_b, e.sig_b);
        chk($sformatf("r%0d_sat_a", e.id), sat_a, e.sat);
        chk($sformatf("r%0d_sat_b", e.id), sat_b, e.sat);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ce_c) begin
      if (q_c.size() == 0) begin
        chk("spurious_ce_c", 1, 0);
      end else begin
        exp_t e;
        e = q_c.pop_front();
        chk($sformatf("r%0d_latency_c", e.id), cyc - e.cyc, 2);
        chk($sformatf("r%0d_ch_c", e.id), ch_c, e.ch);
        chk($sformatf("r%0d_sig_c", e.id), sig_c, e.sig_a);
        chk($sformatf("r%0d_sat_c", e.id), sat_c, e.sat);
      end
    end
  end

  initial begin
    //          ch  u         clr ki_wr ki     sig       sat sig_hold
    tbl[0]  = '{0,  1000,     0,  0,    0,     1,        0,  1};
    tbl[1]  = '{0,  1000,     0,  0,    0,     4,        0,  4};
    tbl[2]  = '{1,  -1000,    0,  0,    0,     -2,       0,  -2};
    tbl[3]  = '{0,  1000,     0,  0,    0,     7,        0,  7};
    tbl[4]  = '{1,  -1000,    0,  0,    0,     -5,       0,  -5};
    tbl[5]  = '{2,  0,        0,  0,    0,     0,        0,  0};
    tbl[6]  = '{3,  0,        0,  0,    0,     0,        0,  0};
    tbl[7]  = '{0,  5000,     1,  0,    0,     0,        0,  0};
    tbl[8]  = '{0,  1000,     0,  0,    0,     1,        0,  1};
    tbl[9]  = '{1,  0,        0,  0,    0,     -6,       0,  -6};
    tbl[10] = '{3,  1000,     0,  0,    0,     499,      0,  499};
    tbl[11] = '{2,  8388607,  0,  1,    32767, 4194175,  0,  4194175};
    tbl[12] = '{2,  8388607,  0,  0,    0,     6291456,  1,  4194175};
    tbl[13] = '{3,  0,        1,  0,    0,     0,        0,  0};
    tbl[14] = '{3,  -8388608, 0,  0,    0,     -4194176, 0,  -4194176};
    tbl[15] = '{3,  -8388608, 0,  0,    0,     -6291456, 1,  -4194176};
    tbl[16] = '{2,  0,        0,  0,    0,     6291456,  1,  4194175};
    tbl[17] = '{1,  0,        0,  0,    0,     -6,       0,  -6};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    // Back-to-back stream; record 10 sits in stage 1 when record 11 writes the gain.
    for (int i = 0; i < 18; i++) begin
      send(tbl[i].ch, tbl[i].u, tbl[i].clr);
      ki_we = tbl[i].ki_wr;
      ki_in = 16'(tbl[i].ki);
      push(i, tbl[i].ch, tbl[i].sig, tbl[i].sig_h, tbl[i].sat);
    end
    idle();
    drain();

    // Reset one cycle after ce_in: the in-flight sample must vanish.
    send(0, 1000, 1'b0);
    @(negedge clk);
    ce_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst1");
    @(negedge clk);
    chk_zero("midrst2");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("after_midrst");

    // Gain back at reset value and channel state cleared.
    send(0, 1000, 1'b0);
    push(100, 0, 1, 1, 1'b0);
    send(2, 0, 1'b0);
    push(101, 2, 0, 0, 1'b0);
    idle();
    drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
